// File: rtl/cpu_program_sequencer_pkg.sv
// Shared types and constants for the cpu program sequencer.
package cpu_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_MEMWAIT,
    S_LOAD,
    S_START,
    S_WBUSY,
    S_WDONE,
    S_PAUSE,
    S_DONE,
    S_ERROR
  } seq_state_t;

  localparam logic [1:0]  ERR_NONE          = 2'd0;
  localparam logic [1:0]  ERR_TIMEOUT       = 2'd1;
  localparam logic [1:0]  ERR_PC_OVF        = 2'd2;
  localparam logic [15:0] DEFAULT_HALT_WORD = 16'hE000;

endpackage

// File: rtl/cpu_program_sequencer_watchdog.sv
// Saturating cycle counter guarding each wait on the cpu w handshake.
module seq_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned   CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Fires on the TIMEOUT-th consecutive enabled cycle since the last clear.
  assign o_expired = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/cpu_program_sequencer.sv
// Fetches instruction words from a synchronous memory and feeds them to the cpu
// over its in/load/s/w handshake, with step mode, abort, HALT detection and watchdog.
module cpu_program_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned AW        = 8,
  parameter logic [15:0] HALT_WORD = DEFAULT_HALT_WORD,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          step_mode,
  input  logic          step,
  input  logic          abort,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [15:0]   mem_rdata,
  output logic [15:0]   cpu_in,
  output logic          cpu_load,
  output logic          cpu_s,
  input  logic          cpu_w,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [AW-1:0] pc,
  output logic [15:0]   retired
);

  seq_state_t    r_state;
  seq_state_t    w_next;
  logic [AW-1:0] r_pc;
  logic [15:0]   r_retired;
  logic [15:0]   r_cpu_in;
  logic [1:0]    r_err_code;
  logic          r_mem_rd, r_cpu_load, r_cpu_s, r_busy, r_done, r_err;
  logic          w_waiting, w_wd_clear, w_expired;
  logic          w_accept, w_retire, w_timeout, w_pc_last;

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_wd_clear),
    .i_enable  (w_waiting),
    .o_expired (w_expired)
  );

  always_comb begin
    w_waiting  = (r_state == S_WBUSY) || (r_state == S_WDONE);
    // Clearing on the WBUSY->WDONE edge restarts the budget for the second wait.
    w_wd_clear = !w_waiting || ((r_state == S_WBUSY) && !cpu_w);
    w_pc_last  = (r_pc == '1);
    w_accept   = 1'b0;
    w_retire   = 1'b0;
    w_timeout  = 1'b0;
    w_next     = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            w_accept = 1'b1;
            w_next   = S_FETCH;
          end
        end
        S_FETCH:   w_next = S_MEMWAIT;
        S_MEMWAIT: w_next = (mem_rdata == HALT_WORD) ? S_DONE : S_LOAD;
        S_LOAD:    w_next = S_START;
        S_START:   w_next = S_WBUSY;
        S_WBUSY: begin
          if (!cpu_w) begin
            w_next = S_WDONE;
          end else if (w_expired) begin
            w_timeout = 1'b1;
            w_next    = S_ERROR;
          end
        end
        S_WDONE: begin
          if (cpu_w) begin
            w_retire = 1'b1;
            if (w_pc_last)      w_next = S_ERROR;
            else if (step_mode) w_next = S_PAUSE;
            else                w_next = S_FETCH;
          end else if (w_expired) begin
            w_timeout = 1'b1;
            w_next    = S_ERROR;
          end
        end
        S_PAUSE: begin
          if (step || !step_mode) w_next = S_FETCH;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so each strobe lines up with its state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_retired  <= '0;
      r_cpu_in   <= '0;
      r_err_code <= ERR_NONE;
      r_mem_rd   <= 1'b0;
      r_cpu_load <= 1'b0;
      r_cpu_s    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_mem_rd   <= (w_next == S_FETCH);
      r_cpu_load <= (w_next == S_LOAD);
      r_cpu_s    <= (w_next == S_START);
      r_busy     <= !(w_next inside {S_IDLE, S_DONE, S_ERROR});
      r_done     <= (w_next == S_DONE);
      r_err      <= (w_next == S_ERROR);
      if (w_accept) begin
        r_pc       <= '0;
        r_retired  <= '0;
        r_err_code <= ERR_NONE;
      end
      if ((r_state == S_MEMWAIT) && (w_next == S_LOAD)) begin
        r_cpu_in <= mem_rdata;
      end
      if (w_retire) begin
        if (r_retired != '1) r_retired <= r_retired + 16'd1;
        if (w_pc_last) r_err_code <= ERR_PC_OVF;
        else           r_pc       <= r_pc + AW'(1);
      end
      if (w_timeout) begin
        r_err_code <= ERR_TIMEOUT;
      end
    end
  end

  assign mem_addr = r_pc;
  assign mem_rd   = r_mem_rd;
  assign cpu_in   = r_cpu_in;
  assign cpu_load = r_cpu_load;
  assign cpu_s    = r_cpu_s;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign err_code = r_err_code;
  assign pc       = r_pc;
  assign retired  = r_retired;

endmodule
